// File: rtl/mcu_pkg.sv
// Shared definitions for the baseline MCU instruction-cycle sequencer:
// op_vec bit order, reset/flush instruction word and sequencer states.
package mcu_pkg;

    localparam int OP_MOVWF  = 0;
    localparam int OP_CLRW   = 1;
    localparam int OP_CLRF   = 2;
    localparam int OP_SUBWF  = 3;
    localparam int OP_DECF   = 4;
    localparam int OP_IORWF  = 5;
    localparam int OP_ANDWF  = 6;
    localparam int OP_XORWF  = 7;
    localparam int OP_ADDWF  = 8;
    localparam int OP_MOVF   = 9;
    localparam int OP_COMF   = 10;
    localparam int OP_INCF   = 11;
    localparam int OP_DECFSZ = 12;
    localparam int OP_RRF    = 13;
    localparam int OP_RLF    = 14;
    localparam int OP_SWAPF  = 15;
    localparam int OP_INCFSZ = 16;
    localparam int OP_BCF    = 17;
    localparam int OP_BSF    = 18;
    localparam int OP_BTFSC  = 19;
    localparam int OP_BTFSS  = 20;
    localparam int OP_RETLW  = 21;
    localparam int OP_MOVLW  = 22;
    localparam int OP_IORLW  = 23;
    localparam int OP_ANDLW  = 24;
    localparam int OP_XORLW  = 25;
    localparam int OP_OPTION = 26;
    localparam int OP_CLRWDT = 27;
    localparam int OP_TRIS   = 28;
    localparam int OP_CALL   = 29;
    localparam int OP_GOTO   = 30;
    localparam int OP_SLEEP  = 31;
    // NOP keeps its slot in the vector but decodes to all-zero, same as a flush.
    localparam int OP_NOP    = 32;

    // Width follows the last index so the vector can never disagree with the op list.
    localparam int OP_W = OP_NOP + 1;

    localparam logic [11:0] NOP_WORD = 12'h000;

    typedef enum logic [1:0] {
        FILL,
        EXEC,
        FLUSH,
        SLEEP
    } state_t;

    typedef logic [OP_W-1:0] op_vec_t;

    function automatic op_vec_t op_bit(input int idx);
        return op_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/mcu_inst_decode.sv
// Combinational 12-bit baseline instruction decoder: one-hot op vector plus
// writeback, skip and branch qualifiers.
module mcu_inst_decode
    import mcu_pkg::*;
(
    input  logic [11:0]     ir,
    output logic [OP_W-1:0] op_vec,
    output logic            wr_w_en,
    output logic            wr_f_en,
    output logic            is_skip,
    output logic            is_branch
);

    int   op_idx;
    logic op_valid;
    logic byte_op;
    logic dest_f;

    always_comb begin
        op_idx   = 0;
        op_valid = 1'b0;
        if (ir[11:10] == 2'b00) begin
            if (ir[9:6] == 4'b0000) begin
                if (ir[5]) begin
                    op_idx   = OP_MOVWF;
                    op_valid = 1'b1;
                end else begin
                    case (ir[4:0])
                        5'h02: begin op_idx = OP_OPTION; op_valid = 1'b1; end
                        5'h03: begin op_idx = OP_SLEEP;  op_valid = 1'b1; end
                        5'h04: begin op_idx = OP_CLRWDT; op_valid = 1'b1; end
                        5'h05, 5'h06, 5'h07: begin op_idx = OP_TRIS; op_valid = 1'b1; end
                        default: op_valid = 1'b0;
                    endcase
                end
            end else if (ir[9:6] == 4'b0001) begin
                if (ir[5]) begin
                    op_idx   = OP_CLRF;
                    op_valid = 1'b1;
                end else if (ir[4:0] == 5'h00) begin
                    op_idx   = OP_CLRW;
                    op_valid = 1'b1;
                end
            end else begin
                // Byte-op opcodes 0010..1111 map in order onto OP_SUBWF..OP_INCFSZ.
                op_idx   = OP_SUBWF + int'(ir[9:6]) - 2;
                op_valid = 1'b1;
            end
        end else if (ir[11:10] == 2'b01) begin
            op_idx   = OP_BCF + int'(ir[9:8]);
            op_valid = 1'b1;
        end else begin
            op_valid = 1'b1;
            case (ir[11:8])
                4'b1000: op_idx = OP_RETLW;
                4'b1001: op_idx = OP_CALL;
                4'b1010, 4'b1011: op_idx = OP_GOTO;
                4'b1100: op_idx = OP_MOVLW;
                4'b1101: op_idx = OP_IORLW;
                4'b1110: op_idx = OP_ANDLW;
                default: op_idx = OP_XORLW;
            endcase
        end
    end

    assign op_vec  = op_valid ? op_bit(op_idx) : '0;
    assign byte_op = |op_vec[OP_INCFSZ:OP_SUBWF];
    assign dest_f  = ir[5];

    assign wr_w_en = (byte_op & ~dest_f) | op_vec[OP_CLRW] | op_vec[OP_RETLW]
                   | op_vec[OP_MOVLW] | op_vec[OP_IORLW] | op_vec[OP_ANDLW] | op_vec[OP_XORLW];

    assign wr_f_en = (byte_op & dest_f) | op_vec[OP_MOVWF] | op_vec[OP_CLRF]
                   | op_vec[OP_BCF] | op_vec[OP_BSF];

    assign is_skip   = op_vec[OP_DECFSZ] | op_vec[OP_INCFSZ] | op_vec[OP_BTFSC] | op_vec[OP_BTFSS];
    assign is_branch = op_vec[OP_GOTO] | op_vec[OP_CALL] | op_vec[OP_RETLW];

endmodule

// File: rtl/mcu_cycle_ctrl.sv
// Instruction-cycle sequencer: Q1..Q4 phase ring, instruction register and
// FILL/EXEC/FLUSH/SLEEP control with phase-gated strobes.
module mcu_cycle_ctrl
    import mcu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            wake,
    input  logic [11:0]     rom_data,
    input  logic            skip,
    output logic [3:0]      q_phase,
    output logic            alu_c2,
    output logic [OP_W-1:0] op_vec,
    output logic [2:0]      deco_bbb,
    output logic [4:0]      f_addr,
    output logic [7:0]      lit,
    output logic [8:0]      br_addr,
    output logic            fetch_en,
    output logic            pc_load,
    output logic            wr_w,
    output logic            wr_f
);

    state_t          state_q, state_d;
    logic [3:0]      phase_q, phase_d;
    logic [11:0]     ir_q, ir_d;

    logic [OP_W-1:0] dec_op_vec;
    logic            wr_w_en, wr_f_en, is_skip, is_branch;
    logic            exec;

    mcu_inst_decode u_decode (
        .ir        (ir_q),
        .op_vec    (dec_op_vec),
        .wr_w_en   (wr_w_en),
        .wr_f_en   (wr_f_en),
        .is_skip   (is_skip),
        .is_branch (is_branch)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FILL;
            phase_q <= 4'b0001;
            ir_q    <= NOP_WORD;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ir_q    <= ir_d;
        end
    end

    // stall freezes everything, so it naturally wins over wake and skip sampling.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ir_d    = ir_q;
        if (!stall) begin
            if (state_q == SLEEP) begin
                if (phase_q[0] && wake) begin
                    state_d = EXEC;
                    phase_d = 4'b0010;
                end
            end else begin
                phase_d = {phase_q[2:0], phase_q[3]};
                if (phase_q[3]) begin
                    state_d = EXEC;
                    ir_d    = rom_data;
                    if (state_q == EXEC) begin
                        if (dec_op_vec[OP_SLEEP]) begin
                            state_d = SLEEP;
                        end else if (is_branch || (is_skip && skip)) begin
                            state_d = FLUSH;
                            ir_d    = NOP_WORD;
                        end
                    end
                end
            end
        end
    end

    // Outputs depend only on registered state, so a stall holds them as they are.
    always_comb begin
        exec     = (state_q == EXEC);
        q_phase  = phase_q;
        op_vec   = exec ? dec_op_vec : '0;
        alu_c2   = exec && phase_q[2];
        fetch_en = (state_q != SLEEP) && phase_q[3];
        pc_load  = exec && phase_q[3] && is_branch;
        wr_w     = exec && phase_q[3] && wr_w_en;
        wr_f     = exec && phase_q[3] && wr_f_en;
        deco_bbb = ir_q[7:5];
        f_addr   = ir_q[4:0];
        lit      = ir_q[7:0];
        br_addr  = dec_op_vec[OP_CALL] ? {1'b0, ir_q[7:0]} : ir_q[8:0];
    end

endmodule

// File: tb/tb_mcu_cycle_ctrl.sv
// Directed self-checking bench for mcu_cycle_ctrl: reset, fill, execute,
// skip flush, branch flush, sleep/wake, stall and mid-cycle reset.
module tb_mcu_cycle_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        wake;
    logic [11:0] rom_data;
    logic        skip;
    logic [3:0]  q_phase;
    logic        alu_c2;
    logic [32:0] op_vec;
    logic [2:0]  deco_bbb;
    logic [4:0]  f_addr;
    logic [7:0]  lit;
    logic [8:0]  br_addr;
    logic        fetch_en;
    logic        pc_load;
    logic        wr_w;
    logic        wr_f;

    int total = 0;
    int bad   = 0;

    mcu_cycle_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .wake     (wake),
        .rom_data (rom_data),
        .skip     (skip),
        .q_phase  (q_phase),
        .alu_c2   (alu_c2),
        .op_vec   (op_vec),
        .deco_bbb (deco_bbb),
        .f_addr   (f_addr),
        .lit      (lit),
        .br_addr  (br_addr),
        .fetch_en (fetch_en),
        .pc_load  (pc_load),
        .wr_w     (wr_w),
        .wr_f     (wr_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] exp_op(input int idx);
        return 33'(1) << idx;
    endfunction

    task automatic applyStimulus(input logic [11:0] rom, input logic sk, input logic wk,
                                 input logic stl, input logic rst, input int n);
        rom_data = rom;
        skip     = sk;
        wake     = wk;
        stall    = stl;
        reset    = rst;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        applyStimulus(12'h000, 0, 0, 0, 0, 2);
        checkOutput("rst_q",     64'(q_phase),  64'(4'b0001));
        checkOutput("rst_op",    64'(op_vec),   64'(0));
        checkOutput("rst_c2",    64'(alu_c2),   64'(0));
        checkOutput("rst_fetch", 64'(fetch_en), 64'(0));
        checkOutput("rst_pcl",   64'(pc_load),  64'(0));
        checkOutput("rst_wrw",   64'(wr_w),     64'(0));
        checkOutput("rst_wrf",   64'(wr_f),     64'(0));

        applyStimulus(12'hC5A, 0, 0, 0, 1, 2);
        checkOutput("fill_q3",    64'(q_phase),  64'(4'b0100));
        checkOutput("fill_c2",    64'(alu_c2),   64'(0));
        applyStimulus(12'hC5A, 0, 0, 0, 1, 1);
        checkOutput("fill_fetch", 64'(fetch_en), 64'(1));
        checkOutput("fill_wrw",   64'(wr_w),     64'(0));

        applyStimulus(12'hC5A, 0, 0, 0, 1, 1);
        checkOutput("movlw_q",  64'(q_phase), 64'(4'b0001));
        checkOutput("movlw_op", 64'(op_vec),  64'(exp_op(22)));
        checkOutput("movlw_lit", 64'(lit),    64'(8'h5A));
        applyStimulus(12'hC5A, 0, 0, 0, 1, 2);
        checkOutput("movlw_c2",  64'(alu_c2), 64'(1));
        checkOutput("movlw_wrw_q3", 64'(wr_w), 64'(0));
        applyStimulus(12'h1E3, 0, 0, 0, 1, 1);
        checkOutput("movlw_wrw",   64'(wr_w),     64'(1));
        checkOutput("movlw_wrf",   64'(wr_f),     64'(0));
        checkOutput("movlw_c2_q4", 64'(alu_c2),   64'(0));
        checkOutput("movlw_fetch", 64'(fetch_en), 64'(1));

        applyStimulus(12'h1E3, 0, 0, 0, 1, 1);
        checkOutput("addwf_op", 64'(op_vec), 64'(exp_op(8)));
        checkOutput("addwf_f",  64'(f_addr), 64'(5'd3));
        applyStimulus(12'h1E3, 0, 0, 0, 1, 2);
        checkOutput("addwf_c2", 64'(alu_c2), 64'(1));
        applyStimulus(12'h2E4, 0, 0, 0, 1, 1);
        checkOutput("addwf_wrf", 64'(wr_f),    64'(1));
        checkOutput("addwf_wrw", 64'(wr_w),    64'(0));
        checkOutput("addwf_pcl", 64'(pc_load), 64'(0));

        applyStimulus(12'h2E4, 0, 0, 0, 1, 1);
        checkOutput("decfsz_op", 64'(op_vec), 64'(exp_op(12)));
        applyStimulus(12'h2E4, 0, 0, 0, 1, 2);
        applyStimulus(12'hC11, 1, 0, 0, 1, 1);
        checkOutput("decfsz_wrf", 64'(wr_f), 64'(1));
        applyStimulus(12'hC11, 1, 0, 0, 1, 1);
        checkOutput("skip_flush_q",  64'(q_phase), 64'(4'b0001));
        checkOutput("skip_flush_op", 64'(op_vec),  64'(0));
        applyStimulus(12'h000, 0, 0, 0, 1, 2);
        checkOutput("skip_flush_c2", 64'(alu_c2), 64'(0));
        applyStimulus(12'h2E4, 0, 0, 0, 1, 1);
        checkOutput("skip_flush_wrf",   64'(wr_f),     64'(0));
        checkOutput("skip_flush_fetch", 64'(fetch_en), 64'(1));

        applyStimulus(12'h2E4, 0, 0, 0, 1, 1);
        checkOutput("decfsz2_op", 64'(op_vec), 64'(exp_op(12)));
        applyStimulus(12'h2E4, 0, 0, 0, 1, 2);
        applyStimulus(12'hC22, 0, 0, 0, 1, 1);
        applyStimulus(12'hC22, 0, 0, 0, 1, 1);
        checkOutput("noskip_op",  64'(op_vec), 64'(exp_op(22)));
        checkOutput("noskip_lit", 64'(lit),    64'(8'h22));
        applyStimulus(12'hC22, 0, 0, 0, 1, 2);
        checkOutput("noskip_c2", 64'(alu_c2), 64'(1));
        applyStimulus(12'hA10, 0, 0, 0, 1, 1);

        applyStimulus(12'hA10, 0, 0, 0, 1, 1);
        checkOutput("goto_op",  64'(op_vec),  64'(exp_op(30)));
        checkOutput("goto_br",  64'(br_addr), 64'(9'h010));
        applyStimulus(12'hA10, 0, 0, 0, 1, 2);
        applyStimulus(12'hC33, 0, 0, 0, 1, 1);
        checkOutput("goto_pcl",   64'(pc_load),  64'(1));
        checkOutput("goto_fetch", 64'(fetch_en), 64'(1));
        applyStimulus(12'hC33, 0, 0, 0, 1, 1);
        checkOutput("goto_flush_op", 64'(op_vec), 64'(0));
        applyStimulus(12'hC33, 0, 0, 0, 1, 2);
        checkOutput("goto_flush_c2", 64'(alu_c2), 64'(0));
        applyStimulus(12'h003, 0, 0, 0, 1, 1);
        checkOutput("goto_flush_pcl", 64'(pc_load), 64'(0));

        applyStimulus(12'h003, 0, 0, 0, 1, 1);
        checkOutput("sleep_op", 64'(op_vec), 64'(exp_op(31)));
        applyStimulus(12'h003, 0, 0, 0, 1, 2);
        applyStimulus(12'hC44, 0, 0, 0, 1, 1);
        checkOutput("sleep_entry_fetch", 64'(fetch_en), 64'(1));
        applyStimulus(12'hC44, 0, 0, 0, 1, 1);
        checkOutput("sleep_in_q",  64'(q_phase), 64'(4'b0001));
        checkOutput("sleep_in_op", 64'(op_vec),  64'(0));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(12'h000, 0, 0, 0, 1, 1);
            checkOutput("sleep_hold_q",     64'(q_phase),  64'(4'b0001));
            checkOutput("sleep_hold_fetch", 64'(fetch_en), 64'(0));
        end
        applyStimulus(12'h000, 0, 1, 0, 1, 1);
        checkOutput("wake_q",   64'(q_phase), 64'(4'b0010));
        checkOutput("wake_op",  64'(op_vec),  64'(exp_op(22)));
        checkOutput("wake_lit", 64'(lit),     64'(8'h44));
        applyStimulus(12'h000, 0, 0, 0, 1, 1);
        checkOutput("wake_c2", 64'(alu_c2), 64'(1));
        applyStimulus(12'h1E3, 0, 0, 0, 1, 1);
        checkOutput("wake_fetch", 64'(fetch_en), 64'(1));
        checkOutput("wake_wrw",   64'(wr_w),     64'(1));

        applyStimulus(12'h1E3, 0, 0, 0, 1, 1);
        applyStimulus(12'h1E3, 0, 0, 1, 1, 3);
        checkOutput("stall_q",  64'(q_phase), 64'(4'b0001));
        checkOutput("stall_op", 64'(op_vec),  64'(exp_op(8)));
        applyStimulus(12'h1E3, 0, 0, 0, 1, 2);
        checkOutput("stall_c2", 64'(alu_c2), 64'(1));
        applyStimulus(12'h1E3, 0, 0, 0, 0, 1);
        checkOutput("midrst_q",   64'(q_phase), 64'(4'b0001));
        checkOutput("midrst_wrf", 64'(wr_f),    64'(0));
        checkOutput("midrst_op",  64'(op_vec),  64'(0));
        checkOutput("midrst_c2",  64'(alu_c2),  64'(0));

        applyStimulus(12'hFFF, 0, 0, 0, 1, 1);
        applyStimulus(12'hFFF, 0, 0, 0, 1, 2);
        checkOutput("refill_fetch", 64'(fetch_en), 64'(1));
        checkOutput("refill_wrw",   64'(wr_w),     64'(0));
        applyStimulus(12'hFFF, 0, 0, 0, 1, 1);
        checkOutput("xorlw_op", 64'(op_vec), 64'(exp_op(25)));
        applyStimulus(12'hFFF, 0, 0, 0, 1, 2);
        applyStimulus(12'h008, 0, 0, 0, 1, 1);
        checkOutput("xorlw_wrw", 64'(wr_w), 64'(1));
        applyStimulus(12'h008, 0, 0, 0, 1, 1);
        checkOutput("undef_op", 64'(op_vec), 64'(0));
        applyStimulus(12'h008, 0, 0, 0, 1, 2);
        applyStimulus(12'h9AB, 0, 0, 0, 1, 1);
        checkOutput("undef_wrw", 64'(wr_w),    64'(0));
        checkOutput("undef_wrf", 64'(wr_f),    64'(0));
        checkOutput("undef_pcl", 64'(pc_load), 64'(0));

        applyStimulus(12'h9AB, 0, 0, 0, 1, 1);
        checkOutput("call_op", 64'(op_vec),  64'(exp_op(29)));
        checkOutput("call_br", 64'(br_addr), 64'(9'h0AB));
        applyStimulus(12'h9AB, 0, 0, 0, 1, 3);
        checkOutput("call_pcl", 64'(pc_load), 64'(1));
        checkOutput("call_wrw", 64'(wr_w),    64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
